lsu_mem_initiator: RTL and testbench

Load/store unit that acts as the requesting end of the execute-to-data-memory interface (`type_exe2mem_s` out, `type_mem2wrb_s` in). It takes one load or store per transaction from the execute stage, converts byte addresses to word-index requests, and sign- or zero-extends load data. Sub-word stores are done as read-modify-write because the memory has no byte enables. It sits between the execute stage and the shared dual-port memory, on the data port that has priority over instruction fetch.

---
 rtl/lsu_mem_initiator_pkg.sv | 69 ++++++
 rtl/lsu_data_align.sv | 44 ++++
 rtl/lsu_mem_initiator.sv | 148 ++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_initiator_pkg.sv
// Shared types for the LSU data-memory initiator: memory bundles, access sizes,
// FSM states and lane helpers.
package lsu_mem_initiator_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned SH_W   = $clog2(XLEN);

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] w_data;
    logic            w_en;
    logic            req;
  } type_exe2mem_s;

  typedef struct packed {
    logic [XLEN-1:0] r_data;
    logic            ack;
  } type_mem2wrb_s;

  typedef enum logic [1:0] {
    LSU_SZ_BYTE = 2'b00,
    LSU_SZ_HALF = 2'b01,
    LSU_SZ_WORD = 2'b10
  } type_lsu_size_e;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_RD,
    LSU_RMW_RD,
    LSU_RMW_WR,
    LSU_DONE
  } type_lsu_state_e;

  // Transaction fields captured at accept
  typedef struct packed {
    logic            we;
    type_lsu_size_e  size;
    logic            is_unsigned;
    logic            err;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } type_lsu_txn_s;

  // Encoding 2'b11 behaves as a full word
  function automatic type_lsu_size_e lsu_size_decode(input logic [1:0] raw);
    case (raw)
      2'b00:   return LSU_SZ_BYTE;
      2'b01:   return LSU_SZ_HALF;
      default: return LSU_SZ_WORD;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input type_lsu_size_e size,
                                          input logic [LANE_W-1:0] lane);
    case (size)
      LSU_SZ_HALF: return lane[0];
      LSU_SZ_WORD: return |lane;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] lsu_word_index(input logic [XLEN-1:0] addr);
    return {{LANE_W{1'b0}}, addr[XLEN-1:LANE_W]};
  endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Lane steering for the LSU: extract/extend load data, and merge a byte or half
// store into the word read back from memory.
module lsu_data_align
  import lsu_mem_initiator_pkg::*;
(
  input  logic [XLEN-1:0]   r_data,
  input  logic [XLEN-1:0]   wdata,
  input  type_lsu_size_e    size,
  input  logic              is_unsigned,
  input  logic [LANE_W-1:0] lane,
  output logic [XLEN-1:0]   load_data_c,
  output logic [XLEN-1:0]   store_data_c
);

  logic [SH_W-1:0]   byte_sh;
  logic [SH_W-1:0]   half_sh;
  logic [BYTE_W-1:0] byte_c;
  logic [HALF_W-1:0] half_c;

  assign byte_sh = {lane, 3'b000};
  assign half_sh = {lane[1], 4'b0000};

  // Little-endian lanes: byte at 8*lane, half at 16*lane[1]
  always_comb begin
    byte_c       = r_data[byte_sh +: BYTE_W];
    half_c       = r_data[half_sh +: HALF_W];
    load_data_c  = r_data;
    store_data_c = wdata;
    case (size)
      LSU_SZ_BYTE: begin
        load_data_c  = {{(XLEN-BYTE_W){byte_c[BYTE_W-1] & ~is_unsigned}}, byte_c};
        store_data_c = r_data;
        store_data_c[byte_sh +: BYTE_W] = wdata[BYTE_W-1:0];
      end
      LSU_SZ_HALF: begin
        load_data_c  = {{(XLEN-HALF_W){half_c[HALF_W-1] & ~is_unsigned}}, half_c};
        store_data_c = r_data;
        store_data_c[half_sh +: HALF_W] = wdata[HALF_W-1:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Load/store unit driving the data-memory port; sub-word stores are done as
// read-modify-write since the memory has no byte enables.
module lsu_mem_initiator
  import lsu_mem_initiator_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [1:0]      lsu_size_i,
  input  logic            lsu_unsigned_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  output logic            lsu_busy_o,
  output logic            lsu_done_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            lsu_misaligned_o,
  output type_exe2mem_s   exe2mem_o,
  input  type_mem2wrb_s   mem2wrb_i
);

  type_lsu_state_e state_q, state_d;
  type_lsu_txn_s   txn_q, txn_d;
  logic [XLEN-1:0] merged_q, merged_d;
  logic [XLEN-1:0] ldata_q, ldata_d;

  type_exe2mem_s   exe2mem_d;
  logic            busy_d, done_d, mis_d;
  logic [XLEN-1:0] rdata_d;

  type_lsu_size_e  size_c;
  logic            mis_c;
  logic [XLEN-1:0] load_data_c, store_data_c;

  lsu_data_align u_align (
    .r_data       (mem2wrb_i.r_data),
    .wdata        (txn_q.wdata),
    .size         (txn_q.size),
    .is_unsigned  (txn_q.is_unsigned),
    .lane         (txn_q.addr[LANE_W-1:0]),
    .load_data_c  (load_data_c),
    .store_data_c (store_data_c)
  );

  // State, capture and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= LSU_IDLE;
      txn_q            <= '0;
      merged_q         <= '0;
      ldata_q          <= '0;
      exe2mem_o        <= '0;
      lsu_busy_o       <= 1'b0;
      lsu_done_o       <= 1'b0;
      lsu_rdata_o      <= '0;
      lsu_misaligned_o <= 1'b0;
    end else begin
      state_q          <= state_d;
      txn_q            <= txn_d;
      merged_q         <= merged_d;
      ldata_q          <= ldata_d;
      exe2mem_o        <= exe2mem_d;
      lsu_busy_o       <= busy_d;
      lsu_done_o       <= done_d;
      lsu_rdata_o      <= rdata_d;
      lsu_misaligned_o <= mis_d;
    end
  end

  // Next state, then outputs decoded from the next state so they register with it
  always_comb begin
    state_d   = state_q;
    txn_d     = txn_q;
    merged_d  = merged_q;
    ldata_d   = ldata_q;
    exe2mem_d = '0;
    size_c    = lsu_size_decode(lsu_size_i);
    mis_c     = lsu_misaligned(size_c, lsu_addr_i[LANE_W-1:0]);

    case (state_q)
      LSU_IDLE: begin
        if (lsu_req_i) begin
          txn_d.we          = lsu_we_i;
          txn_d.size        = size_c;
          txn_d.is_unsigned = lsu_unsigned_i;
          txn_d.err         = mis_c;
          txn_d.addr        = lsu_addr_i;
          txn_d.wdata       = lsu_wdata_i;
          ldata_d           = '0;
          if (mis_c) begin
            state_d = LSU_DONE;
          end else if (lsu_we_i && (size_c != LSU_SZ_WORD)) begin
            state_d = LSU_RMW_RD;
          end else begin
            state_d = LSU_RD;
          end
        end
      end
      LSU_RD: begin
        if (mem2wrb_i.ack) begin
          if (!txn_q.we) begin
            ldata_d = load_data_c;
          end
          state_d = LSU_DONE;
        end
      end
      LSU_RMW_RD: begin
        if (mem2wrb_i.ack) begin
          merged_d = store_data_c;
          state_d  = LSU_RMW_WR;
        end
      end
      LSU_RMW_WR: begin
        if (mem2wrb_i.ack) begin
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase

    case (state_d)
      LSU_RD: begin
        exe2mem_d.req    = 1'b1;
        exe2mem_d.w_en   = txn_d.we;
        exe2mem_d.addr   = lsu_word_index(txn_d.addr);
        exe2mem_d.w_data = txn_d.wdata;
      end
      LSU_RMW_RD: begin
        exe2mem_d.req  = 1'b1;
        exe2mem_d.addr = lsu_word_index(txn_d.addr);
      end
      LSU_RMW_WR: begin
        exe2mem_d.req    = 1'b1;
        exe2mem_d.w_en   = 1'b1;
        exe2mem_d.addr   = lsu_word_index(txn_d.addr);
        exe2mem_d.w_data = merged_d;
      end
      default: ;
    endcase

    busy_d  = (state_d != LSU_IDLE);
    done_d  = (state_d == LSU_DONE);
    rdata_d = done_d ? ldata_d : '0;
    mis_d   = done_d & txn_d.err;
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator: memory slave with configurable ack delay,
// transaction-level expectation model and a per-cycle output checker.
module tb_lsu_mem_initiator;
  import lsu_mem_initiator_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        lsu_req_i = 1'b0;
  logic        lsu_we_i = 1'b0;
  logic [1:0]  lsu_size_i = 2'b00;
  logic        lsu_unsigned_i = 1'b0;
  logic [31:0] lsu_addr_i = '0;
  logic [31:0] lsu_wdata_i = '0;
  logic        lsu_busy_o, lsu_done_o, lsu_misaligned_o;
  logic [31:0] lsu_rdata_o;
  type_exe2mem_s exe2mem;
  type_mem2wrb_s mem2wrb;

  always #5 clk = ~clk;

  lsu_mem_initiator dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lsu_req_i        (lsu_req_i),
    .lsu_we_i         (lsu_we_i),
    .lsu_size_i       (lsu_size_i),
    .lsu_unsigned_i   (lsu_unsigned_i),
    .lsu_addr_i       (lsu_addr_i),
    .lsu_wdata_i      (lsu_wdata_i),
    .lsu_busy_o       (lsu_busy_o),
    .lsu_done_o       (lsu_done_o),
    .lsu_rdata_o      (lsu_rdata_o),
    .lsu_misaligned_o (lsu_misaligned_o),
    .exe2mem_o        (exe2mem),
    .mem2wrb_i        (mem2wrb)
  );

  int total = 0;
  int bad = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory slave: acks after ack_delay edges of req, ignores req in its ack cycle
  logic [31:0] mem [0:63];
  logic        mem_loaded = 1'b0;
  logic        mem_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  int          wait_cnt = 0;
  int          ack_delay = 1;

  assign mem2wrb = {mem_rdata, mem_ack | stray_ack};

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem[4] <= 32'h4444_4444;
      mem[5] <= 32'hDEAD_BEEF;
      mem[7] <= 32'h0102_0304;
      mem_loaded <= 1'b1;
    end else if (mem_ack) begin
      mem_ack  <= 1'b0;
      wait_cnt <= 0;
    end else if (exe2mem.req) begin
      if (wait_cnt + 1 >= ack_delay) begin
        mem_ack   <= 1'b1;
        mem_rdata <= mem[exe2mem.addr[5:0]];
        if (exe2mem.w_en) mem[exe2mem.addr[5:0]] <= exe2mem.w_data;
        wait_cnt  <= 0;
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_mis(input logic [1:0] sz, input logic [31:0] a);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
    int n = nbytes(sz);
    logic [31:0] mask, v;
    if (n == 4) return word;
    mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = (word >> (8 * (a % 4))) & mask;
    if (!uns && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] word, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] wd);
    int n = nbytes(sz);
    logic [31:0] mask;
    if (n == 4) return wd;
    mask = ((n == 1) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * (a % 4));
    return (word & ~mask) | ((wd << (8 * (a % 4))) & mask);
  endfunction

  // Transaction-level model: what the LSU owes for each accepted request
  logic        live = 1'b0;
  int          k = 0;
  int          lat_exp = 0;
  int          acc_count = 0;
  int          m_d = 1;
  logic [31:0] m_widx = '0, m_wdata = '0, m_merged = '0, m_rdata = '0;
  logic        m_we = 1'b0, m_rmw = 1'b0, m_mis = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live <= 1'b0;
      k    <= 0;
    end else if (live) begin
      if (k >= lat_exp) live <= 1'b0;
      else k <= k + 1;
    end else if (lsu_req_i) begin
      live      <= 1'b1;
      k         <= 1;
      acc_count <= acc_count + 1;
      m_d       <= ack_delay;
      m_widx    <= lsu_addr_i >> 2;
      m_we      <= lsu_we_i;
      m_wdata   <= lsu_wdata_i;
      m_mis     <= model_mis(lsu_size_i, lsu_addr_i);
      m_rmw     <= lsu_we_i && (nbytes(lsu_size_i) < 4);
      m_merged  <= model_store(mem[lsu_addr_i[7:2]], lsu_addr_i, lsu_size_i, lsu_wdata_i);
      m_rdata   <= (lsu_we_i || model_mis(lsu_size_i, lsu_addr_i)) ? 32'h0 :
                   model_load(mem[lsu_addr_i[7:2]], lsu_addr_i, lsu_size_i, lsu_unsigned_i);
      lat_exp   <= model_mis(lsu_size_i, lsu_addr_i) ? 1 :
                   (lsu_we_i && (nbytes(lsu_size_i) < 4)) ? 3 + 2 * ack_delay : 2 + ack_delay;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic        exp_req, exp_wen, exp_done;
    logic [31:0] exp_wdata;
    if (chk_en) begin
      exp_req   = 1'b0;
      exp_wen   = 1'b0;
      exp_wdata = '0;
      exp_done  = live && (k == lat_exp);
      if (live && !m_mis) begin
        if (k <= 1 + m_d) begin
          exp_req   = 1'b1;
          exp_wen   = m_we && !m_rmw;
          exp_wdata = m_wdata;
        end else if (m_rmw && k <= 2 + 2 * m_d) begin
          exp_req   = 1'b1;
          exp_wen   = 1'b1;
          exp_wdata = m_merged;
        end
      end
      chk("busy", 32'(lsu_busy_o), 32'(live));
      chk("done", 32'(lsu_done_o), 32'(exp_done));
      chk("rdata", lsu_rdata_o, exp_done ? m_rdata : 32'h0);
      chk("misaligned", 32'(lsu_misaligned_o), 32'(exp_done && m_mis));
      chk("req", 32'(exe2mem.req), 32'(exp_req));
      if (exp_req) begin
        chk("addr", exe2mem.addr, m_widx);
        chk("w_en", 32'(exe2mem.w_en), 32'(exp_wen));
        if (exp_wen) chk("w_data", exe2mem.w_data, exp_wdata);
      end else begin
        chk("bundle_idle_addr", exe2mem.addr, 32'h0);
        chk("bundle_idle_wdata", exe2mem.w_data, 32'h0);
        chk("bundle_idle_wen", 32'(exe2mem.w_en), 32'h0);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, output bit got);
    int base;
    @(posedge clk); #2;
    lsu_we_i = we; lsu_size_i = sz; lsu_unsigned_i = uns;
    lsu_addr_i = a; lsu_wdata_i = wd; lsu_req_i = 1'b1;
    base = acc_count;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (acc_count != base) got = 1'b1;
    end
    lsu_req_i = 1'b0;
  endtask

  task automatic run_txn(input string name, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rdata, input logic exp_mis, input int exp_lat);
    bit got;
    int lat;
    issue(we, sz, uns, a, wd, got);
    chk({name, "_accept"}, 32'(got), 32'h1);
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (lsu_done_o) begin
        got = 1'b1;
        lat = i;
      end
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_rdata"}, lsu_rdata_o, exp_rdata);
    chk({name, "_mis"}, 32'(lsu_misaligned_o), 32'(exp_mis));
  endtask

  initial begin
    bit got;
    int cyc, first, second;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(lsu_busy_o), 32'h0);
    chk("reset_done", 32'(lsu_done_o), 32'h0);
    chk("reset_rdata", lsu_rdata_o, 32'h0);
    chk("reset_bundle", 32'({exe2mem.req, exe2mem.w_en}) | exe2mem.addr | exe2mem.w_data, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    run_txn("lw_14",  1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
    run_txn("lb_17",  1'b0, 2'b00, 1'b0, 32'h17, 32'h0, 32'hFFFF_FFDE, 1'b0, 3);
    run_txn("lbu_17", 1'b0, 2'b00, 1'b1, 32'h17, 32'h0, 32'h0000_00DE, 1'b0, 3);
    run_txn("lh_16",  1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 32'hFFFF_DEAD, 1'b0, 3);
    run_txn("lhu_14", 1'b0, 2'b01, 1'b1, 32'h14, 32'h0, 32'h0000_BEEF, 1'b0, 3);
    run_txn("sb_15",  1'b1, 2'b00, 1'b0, 32'h15, 32'h55, 32'h0, 1'b0, 5);
    chk("mem5_after_sb", mem[5], 32'hDEAD_55EF);
    run_txn("sh_16",  1'b1, 2'b01, 1'b0, 32'h16, 32'h1234, 32'h0, 1'b0, 5);
    chk("mem5_after_sh", mem[5], 32'h1234_55EF);
    run_txn("sw_18",  1'b1, 2'b10, 1'b0, 32'h18, 32'hCAFE_F00D, 32'h0, 1'b0, 3);
    chk("mem6_after_sw", mem[6], 32'hCAFE_F00D);
    run_txn("lh_13_mis", 1'b0, 2'b01, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1);
    run_txn("sw_12_mis", 1'b1, 2'b10, 1'b0, 32'h12, 32'h9999_9999, 32'h0, 1'b1, 1);
    chk("mem4_untouched", mem[4], 32'h4444_4444);
    run_txn("size3_18", 1'b0, 2'b11, 1'b0, 32'h18, 32'h0, 32'hCAFE_F00D, 1'b0, 3);

    ack_delay = 4;
    run_txn("lw_14_slow", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h1234_55EF, 1'b0, 6);
    run_txn("sb_14_slow", 1'b1, 2'b00, 1'b0, 32'h14, 32'hA5, 32'h0, 1'b0, 11);
    chk("mem5_after_slow_sb", mem[5], 32'h1234_55A5);
    ack_delay = 1;

    // Request held high: second accept only after DONE has passed
    @(posedge clk); #2;
    lsu_we_i = 1'b0; lsu_size_i = 2'b00; lsu_unsigned_i = 1'b1;
    lsu_addr_i = 32'h15; lsu_req_i = 1'b1;
    first = -1; second = -1; cyc = 0;
    for (int i = 0; i < 30 && second < 0; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (first < 0 && acc_count > 0 && live && k == 1) first = cyc;
      else if (first >= 0 && live && k == 1) second = cyc;
    end
    lsu_req_i = 1'b0;
    chk("b2b_gap", 32'(second - first), 32'd4);
    for (int i = 0; i < 20 && live; i++) @(posedge clk);
    @(negedge clk);

    // Reset while the write half of an RMW is pending
    issue(1'b1, 2'b00, 1'b0, 32'h1D, 32'hFF, got);
    chk("rmw_rst_accept", 32'(got), 32'h1);
    repeat (3) @(negedge clk);
    chk("rmw_rst_in_write", 32'({exe2mem.req, exe2mem.w_en}), 32'h3);
    #1 rst_n = 1'b0;
    #1 chk("rmw_rst_req_drop", 32'(exe2mem.req), 32'h0);
    chk("rmw_rst_busy_drop", 32'(lsu_busy_o), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2 stray_ack = 1'b1;
    @(posedge clk); #2 stray_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_idle", 32'(lsu_busy_o), 32'h0);
    chk("mem7_unmodified", mem[7], 32'h0102_0304);
    run_txn("lw_1c_after_rst", 1'b0, 2'b10, 1'b0, 32'h1C, 32'h0, 32'h0102_0304, 1'b0, 3);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
